// File: rtl/nibble_serial_add_sub_if.sv
// Handshake and operand/result bundle for nibble_serial_add_sub.
// master: start, ctrl, a, b out; busy, done, sum, carry, overflow in.
// slave : the mirror image, used by the arithmetic block.
interface nibble_serial_add_sub_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned WIDTH = 4 * NIBBLES;

    logic             start;
    logic             ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, ctrl, a, b,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, ctrl, a, b,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/nibble_serial_add_sub.sv
// Word-wide add/subtract computed one 4-bit slice per clock, LSB nibble first.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   bus.start  - request, accepted in IDLE or DONE
//   bus.ctrl   - 0 = a+b, 1 = a-b (latched with start)
//   bus.a/b    - operands (latched with start)
//   bus.busy   - high while nibbles are processed
//   bus.done   - one-cycle pulse when results are valid
//   bus.sum    - result modulo 2^WIDTH
//   bus.carry  - carry out of MSB (subtract: 1 = no borrow)
//   bus.overflow - two's-complement signed overflow
module nibble_serial_add_sub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_add_sub_if.slave bus
);
    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [WIDTH-1:0]  sum_q, sum_n;
    logic              carry_q, carry_n;
    logic              ovf_q, ovf_n;
    logic [IDXW-1:0]   idx_q, idx_n;
    logic [WIDTH-1:0]  a_q, a_n;
    logic [WIDTH-1:0]  b_q, b_n;
    logic              ctrl_q, ctrl_n;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [3:0]        eb;
    logic [4:0]        nib_sum;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            sum_q   <= sum_n;
            carry_q <= carry_n;
            ovf_q   <= ovf_n;
            idx_q   <= idx_n;
            a_q     <= a_n;
            b_q     <= b_n;
            ctrl_q  <= ctrl_n;
        end
    end

    // Next-state, nibble slice and result update
    always_comb begin
        state_n = state_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        sum_n   = sum_q;
        carry_n = carry_q;
        ovf_n   = ovf_q;
        idx_n   = idx_q;
        a_n     = a_q;
        b_n     = b_q;
        ctrl_n  = ctrl_q;
        a_nib   = 4'h0;
        b_nib   = 4'h0;

        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end

        // Subtract is a + ~b + 1; the +1 arrives as the initial carry.
        eb      = b_nib ^ {4{ctrl_q}};
        nib_sum = {1'b0, a_nib} + {1'b0, eb} + 5'(carry_q);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = BUSY;
                    busy_n  = 1'b1;
                    a_n     = bus.a;
                    b_n     = bus.b;
                    ctrl_n  = bus.ctrl;
                    carry_n = bus.ctrl;
                    idx_n   = '0;
                    sum_n   = '0;
                    ovf_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_n[4*i +: 4] = nib_sum[3:0];
                    end
                end
                carry_n = nib_sum[4];
                if (idx_q == IDXW'(NIBBLES - 1)) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    idx_n   = '0;
                    // Top nibble holds the word MSB, so signed overflow is decided here.
                    ovf_n   = (a_nib[3] == eb[3]) && (nib_sum[3] != a_nib[3]);
                end else begin
                    idx_n = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Directed bench for nibble_serial_add_sub at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_add_sub;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    nibble_serial_add_sub_if #(.NIBBLES(4)) if4 ();
    nibble_serial_add_sub_if #(.NIBBLES(1)) if1 ();

    nibble_serial_add_sub #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    nibble_serial_add_sub #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res4(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        chk({tag, ".sum"},   32'(if4.sum),      32'(es));
        chk({tag, ".carry"}, 32'(if4.carry),    32'(ec));
        chk({tag, ".ovf"},   32'(if4.overflow), 32'(eo));
    endtask

    // Launches one 4-nibble operation and returns in its done cycle.
    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] es, input logic ec, input logic eo);
        if4.a     = a;
        if4.b     = b;
        if4.ctrl  = c;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".busy"}, 32'(if4.busy), 32'd1);
            chk({tag, ".nodone"}, 32'(if4.done), 32'd0);
            if (k < 3) tick();
        end
        tick();
        chk({tag, ".done"}, 32'(if4.done), 32'd1);
        chk({tag, ".busy_end"}, 32'(if4.busy), 32'd0);
        chk_res4(tag, es, ec, eo);
    endtask

    initial begin
        int done_cnt;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        if4.start = 1'b0; if4.ctrl = 1'b0; if4.a = '0; if4.b = '0;
        if1.start = 1'b0; if1.ctrl = 1'b0; if1.a = '0; if1.b = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.busy", 32'(if4.busy), 32'd0);
        chk("rst.done", 32'(if4.done), 32'd0);
        chk_res4("rst", 16'h0000, 1'b0, 1'b0);
        chk("rst1.busy", 32'(if1.busy), 32'd0);
        chk("rst1.sum", 32'(if1.sum), 32'd0);

        // Add with ripple; partial nibble visible after first busy edge
        if4.a = 16'h1234; if4.b = 16'h0FFF; if4.ctrl = 1'b0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        chk("add.e0.sum", 32'(if4.sum), 32'h0000);
        chk("add.e0.carry", 32'(if4.carry), 32'd0);
        tick();
        chk("add.e1.sum", 32'(if4.sum), 32'h0003);
        chk("add.e1.carry", 32'(if4.carry), 32'd1);
        chk("add.e1.ovf", 32'(if4.overflow), 32'd0);
        chk("add.e1.busy", 32'(if4.busy), 32'd1);
        tick();
        tick();
        chk("add.e3.busy", 32'(if4.busy), 32'd1);
        chk("add.e3.done", 32'(if4.done), 32'd0);
        tick();
        chk("add.e4.done", 32'(if4.done), 32'd1);
        chk("add.e4.busy", 32'(if4.busy), 32'd0);
        chk_res4("add", 16'h2233, 1'b0, 1'b0);
        tick();
        chk("add.pulse", 32'(if4.done), 32'd0);
        chk_res4("add.hold", 16'h2233, 1'b0, 1'b0);

        // Subtract, then back-to-back start in the done cycle
        op4("sub1", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        op4("sub2", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tick();

        // Signed overflow and wrap
        op4("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();
        op4("ovfsub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tick();
        op4("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();

        // Start while busy is ignored; operand changes have no effect
        if4.a = 16'h00FF; if4.b = 16'h0001; if4.ctrl = 1'b0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        done_cnt = 0;
        tick();
        if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.ctrl = 1'b1; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        if4.a = 16'h5555; if4.b = 16'hAAAA;
        for (int k = 0; k < 10; k++) begin
            if (if4.done) begin
                done_cnt++;
                chk_res4("ign", 16'h0100, 1'b0, 1'b0);
            end
            tick();
        end
        chk("ign.done_cnt", 32'(done_cnt), 32'd1);
        chk("ign.idle", 32'(if4.busy), 32'd0);
        chk_res4("ign.hold", 16'h0100, 1'b0, 1'b0);

        // Reset in the second busy cycle aborts the operation
        if4.a = 16'h1111; if4.b = 16'h2222; if4.ctrl = 1'b0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", 32'(if4.busy), 32'd0);
        chk("abort.done", 32'(if4.done), 32'd0);
        chk_res4("abort", 16'h0000, 1'b0, 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (if4.done) done_cnt++;
            tick();
        end
        chk("abort.no_done", 32'(done_cnt), 32'd0);
        op4("after", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        tick();

        // Single-nibble instance: add then subtract
        if1.a = 4'hB; if1.b = 4'h6; if1.ctrl = 1'b0; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("n1add.busy", 32'(if1.busy), 32'd1);
        chk("n1add.nodone", 32'(if1.done), 32'd0);
        tick();
        chk("n1add.done", 32'(if1.done), 32'd1);
        chk("n1add.busy_end", 32'(if1.busy), 32'd0);
        chk("n1add.sum", 32'(if1.sum), 32'h1);
        chk("n1add.carry", 32'(if1.carry), 32'd1);
        chk("n1add.ovf", 32'(if1.overflow), 32'd0);
        tick();
        if1.ctrl = 1'b1; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("n1sub.busy", 32'(if1.busy), 32'd1);
        tick();
        chk("n1sub.done", 32'(if1.done), 32'd1);
        chk("n1sub.sum", 32'(if1.sum), 32'h5);
        chk("n1sub.carry", 32'(if1.carry), 32'd1);
        chk("n1sub.ovf", 32'(if1.overflow), 32'd1);
        tick();
        chk("n1sub.pulse", 32'(if1.done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_sub.md
Name: nibble_serial_add_sub

Overview:
- Multi-cycle word-wide adder/subtractor built around a 4-bit add/sub slice.
- Latches two WIDTH-bit operands and a ctrl bit (0 = add, 1 = subtract).
- Processes one nibble per clock, LSB nibble first, chaining the carry between nibbles.
- Serves as the sequencing stage that feeds 4-bit add/sub slices wherever wider arithmetic is needed, reporting sum, carry and signed overflow with a start/busy/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand.
- WIDTH = 4*NIBBLES is a derived localparam, not overridable.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is not busy
- ctrl  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when results become valid
- sum  output  WIDTH  result, modulo 2^WIDTH
- carry  output  1  carry out of the MSB (subtract: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous, active-high; rst=1 at a rising edge forces state IDLE and clears busy, done, sum, carry, overflow, the nibble index, the internal carry and the operand registers. Reset wins over any simultaneous start. Reset mid-operation aborts the operation; no done pulse follows.
- States:
  - IDLE -> BUSY when start=1. At that edge (E0): capture a, b, ctrl; set internal carry = ctrl; set index = 0; set busy=1.
  - BUSY: each edge processes nibble[index]:
    - eb = b_nib XOR {4{ctrl}}
    - {c, s} = a_nib + eb + carry
    - write s into sum[4*index+3 : 4*index], set carry = c, index++
  - BUSY -> DONE at the edge that processes nibble NIBBLES-1, i.e. edge E0+NIBBLES. At that edge: busy=0, done=1, carry output = final c, overflow = (a[MSB] == eb[MSB]) && (s[3] != a[MSB]).
  - DONE -> IDLE on the next edge; done is high for exactly one cycle. A start sampled in DONE is accepted as in IDLE (back-to-back operation, no bubble).
- Latency: start at E0 -> done high during the cycle after E0+NIBBLES; busy is high for exactly NIBBLES cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- Input changes on a, b, ctrl during BUSY have no effect (operands are latched).
- sum is zeroed at the edge a start is accepted, so partial nibbles are visible during BUSY. sum, carry and overflow hold their final values after done until the next accepted start or reset.
- carry and overflow are meaningful only when done=1 or afterwards. During BUSY, overflow holds 0 and carry shows the internal chain.
- Width rule: all arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1; the +1 comes from the initial carry = ctrl.

Test Plan:
- Add with inter-nibble ripple: a=16'h1234, b=16'h0FFF, ctrl=0 -> sum=16'h2233, carry=0, overflow=0; done exactly 4 cycles after start edge; busy high for 4 cycles.
- Subtract, with and without borrow: 16'h0005-16'h0003 -> sum=16'h0002, carry=1, overflow=0. Then back-to-back start in the done cycle with 16'h0003-16'h0005 -> sum=16'hFFFE, carry=0, overflow=0, done 4 cycles later.
- Signed overflow and wrap: 16'h7FFF+16'h0001 -> sum=16'h8000, carry=0, overflow=1. 16'h8000-16'h0001 -> sum=16'h7FFF, carry=1, overflow=1. 16'hFFFF+16'h0001 -> sum=16'h0000, carry=1, overflow=0.
- Ignored start and operand stability: start 16'h00FF+16'h0001, then pulse start with different a, b, ctrl two cycles later while busy -> single done, sum=16'h0100, no second done.
- Reset mid-operation: start 16'h1111+16'h2222, assert rst for 1 cycle at the 2nd BUSY cycle -> busy=0, done never pulses, sum=0, carry=0, overflow=0. A following start of 16'h0001+16'h0001 yields sum=16'h0002 after 4 cycles.
- Parameter sweep NIBBLES=1: a=4'hb, b=4'h6, ctrl=0 -> sum=4'h1, carry=1, overflow=0, done 1 cycle after start. ctrl=1 -> sum=4'h5, carry=1, overflow=1.
